// File: rtl/deser_queue_ctrl.sv
// deser_queue_ctrl: moves words from the deserializer into the 8-entry queue.
// It arbitrates the queue's single operation slot between enqueue and host
// dequeue, and it returns a one-cycle acknowledge to the deserializer.
module deser_queue_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_des_ready,
  input  logic [DATA_W-1:0] i_des_data,
  output logic              o_des_ack,
  output logic              o_q_enqueue,
  output logic [DATA_W-1:0] o_q_data,
  output logic              o_q_dequeue,
  input  logic [LEN_W-1:0]  i_q_len,
  input  logic              i_deq_req,
  output logic              o_deq_err,
  output logic              o_full,
  output logic              o_empty
);

  localparam logic [LEN_W-1:0] LP_DEPTH = LEN_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_ACK, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_hold;
  logic              r_deq_pending;
  logic              r_last_deq;   // 1: the most recent grant went to dequeue
  logic              r_blackout;   // cycle after a grant; i_q_len is still stale
  logic              w_capture;
  logic              w_ack;
  logic              w_enq_want;
  logic              w_deq_want;
  logic              w_grant_enq;
  logic              w_grant_deq;
  logic              w_err;

  // Ingress state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Ingress next state: capture once, wait for the grant, ack, then wait for ready to fall.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_ack        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_des_ready) begin
          w_capture    = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_grant_enq) begin
          w_state_next = S_ACK;
        end
      end
      S_ACK: begin
        w_ack        = 1'b1;
        w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!i_des_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Slot arbitration: empty-queue error, single want, or round-robin tie break.
  always_comb begin
    w_enq_want  = (r_state == S_HOLD) && (i_q_len < LP_DEPTH);
    w_deq_want  = r_deq_pending && (i_q_len != '0);
    w_grant_enq = 1'b0;
    w_grant_deq = 1'b0;
    w_err       = 1'b0;
    if (!r_blackout) begin
      w_err = r_deq_pending && (i_q_len == '0);
      if (w_enq_want && w_deq_want) begin
        if (r_last_deq) begin
          w_grant_enq = 1'b1;
        end else begin
          w_grant_deq = 1'b1;
        end
      end else begin
        w_grant_enq = w_enq_want;
        w_grant_deq = w_deq_want;
      end
    end
  end

  // Hold word, pending dequeue request, round-robin memory and settle blackout.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold        <= '0;
      r_deq_pending <= 1'b0;
      r_last_deq    <= 1'b1;
      r_blackout    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_hold <= i_des_data;
      end
      // A new request always sticks, even when it coincides with a grant or an error.
      r_deq_pending <= i_deq_req || (r_deq_pending && !w_grant_deq && !w_err);
      if (w_grant_enq || w_grant_deq) begin
        r_last_deq <= w_grant_deq;
      end
      r_blackout <= w_grant_enq || w_grant_deq;
    end
  end

  assign o_des_ack   = w_ack;
  assign o_q_enqueue = w_grant_enq;
  assign o_q_dequeue = w_grant_deq;
  assign o_q_data    = r_hold;
  assign o_deq_err   = w_err;
  assign o_full      = (i_q_len == LP_DEPTH);
  assign o_empty     = (i_q_len == '0);

endmodule

// File: tb/tb_deser_queue_ctrl.sv
// Bench for deser_queue_ctrl: a queue-length model plus scoreboards of expected
// enqueued words and expected dequeue/error events.
module tb_deser_queue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_des_ready = 1'b0;
  logic [7:0] i_des_data = 8'h00;
  logic       i_deq_req = 1'b0;
  logic [3:0] q_len;
  logic       o_des_ack, o_q_enqueue, o_q_dequeue, o_deq_err, o_full, o_empty;
  logic [7:0] o_q_data;

  int n_checks = 0;
  int n_fail = 0;
  int enq_count = 0;
  int ack_count = 0;
  logic prev_enq = 1'b0;
  logic       seed_en = 1'b0;
  logic [3:0] seed_val = 4'd0;

  logic [7:0] exp_enq[$];
  int         exp_deq[$];   // 1 = dequeue strobe, 2 = empty error

  deser_queue_ctrl #(.DATA_W(8), .DEPTH(8), .LEN_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_des_ready(i_des_ready), .i_des_data(i_des_data), .o_des_ack(o_des_ack),
    .o_q_enqueue(o_q_enqueue), .o_q_data(o_q_data), .o_q_dequeue(o_q_dequeue),
    .i_q_len(q_len), .i_deq_req(i_deq_req), .o_deq_err(o_deq_err),
    .o_full(o_full), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue occupancy model: length follows a strobe by one cycle.
  always @(posedge clk) begin
    if (seed_en) q_len <= seed_val;
    else if (o_q_enqueue && !o_q_dequeue) q_len <= q_len + 4'd1;
    else if (o_q_dequeue && !o_q_enqueue) q_len <= q_len - 4'd1;
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_q_enqueue || o_q_dequeue) check_eq("strobe_excl", {31'd0, o_q_enqueue & o_q_dequeue}, 0);
      if (o_q_enqueue) begin
        enq_count++;
        if (exp_enq.size() == 0) check_eq("enq_unexpected", 1, 0);
        else check_eq("enq_data", {24'd0, o_q_data}, {24'd0, exp_enq.pop_front()});
        $display("txn enqueue data=%02h len=%0d", o_q_data, q_len);
      end
      if (o_des_ack) begin
        ack_count++;
        check_eq("ack_after_enq", {31'd0, prev_enq}, 1);
        $display("txn ack");
      end
      if (o_q_dequeue || o_deq_err) begin
        if (exp_deq.size() == 0) check_eq("deq_unexpected", 1, 0);
        else check_eq("deq_kind", o_q_dequeue ? 1 : 2, exp_deq.pop_front());
        $display("txn %s len=%0d", o_q_dequeue ? "dequeue" : "deq_err", q_len);
      end
    end
    prev_enq = o_q_enqueue;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] len);
    rst_n = 1'b0;
    i_des_ready = 1'b0;
    i_deq_req = 1'b0;
    seed_val = len;
    seed_en = 1'b1;
    #1;
    check_eq("rst_ack", {31'd0, o_des_ack}, 0);
    check_eq("rst_enq", {31'd0, o_q_enqueue}, 0);
    check_eq("rst_deq", {31'd0, o_q_dequeue}, 0);
    check_eq("rst_err", {31'd0, o_deq_err}, 0);
    check_eq("rst_data", {24'd0, o_q_data}, 0);
    step(2);
    seed_en = 1'b0;
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic send_word(input logic [7:0] d);
    int n;
    i_des_data = d;
    i_des_ready = 1'b1;
    exp_enq.push_back(d);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!o_des_ack && n < 20);
    check_eq("ack_seen", {31'd0, o_des_ack}, 1);
    i_des_ready = 1'b0;
    step(2);
  endtask

  task automatic tie_round(input logic [7:0] d, input bit enq_first);
    i_des_data = d;
    i_des_ready = 1'b1;
    i_deq_req = 1'b1;
    exp_deq.push_back(1);
    if (enq_first) exp_enq.push_back(d);
    step(1);
    i_deq_req = 1'b0;
    check_eq("tie_first_enq", {31'd0, o_q_enqueue}, {31'd0, enq_first});
    check_eq("tie_first_deq", {31'd0, o_q_dequeue}, {31'd0, !enq_first});
    step(1);
    check_eq("tie_blackout", {30'd0, o_q_enqueue, o_q_dequeue}, 0);
    if (!enq_first) exp_enq.push_back(d);
    step(1);
    check_eq("tie_second_enq", {31'd0, o_q_enqueue}, {31'd0, !enq_first});
    check_eq("tie_second_deq", {31'd0, o_q_dequeue}, {31'd0, enq_first});
    step(2);
    i_des_ready = 1'b0;
    step(2);
  endtask

  initial begin
    int base_enq, base_ack, held;

    // Single word with ready high for four edges.
    do_reset(4'd0);
    check_eq("empty_reset", {31'd0, o_empty}, 1);
    i_des_data = 8'hA5;
    i_des_ready = 1'b1;
    exp_enq.push_back(8'hA5);
    base_enq = enq_count;
    step(1);
    check_eq("single_enq", {31'd0, o_q_enqueue}, 1);
    check_eq("single_data", {24'd0, o_q_data}, 8'hA5);
    step(1);
    check_eq("single_ack", {31'd0, o_des_ack}, 1);
    check_eq("single_enq_once", {31'd0, o_q_enqueue}, 0);
    step(1);
    check_eq("single_ack_once", {31'd0, o_des_ack}, 0);
    step(1);
    i_des_ready = 1'b0;
    step(2);
    check_eq("single_count", enq_count - base_enq, 1);
    check_eq("single_not_empty", {31'd0, o_empty}, 0);

    // Fill to full, ninth word backpressured until a dequeue frees a slot.
    do_reset(4'd0);
    for (int i = 0; i < 8; i++) send_word(8'h10 + 8'(i));
    check_eq("fill_full", {31'd0, o_full}, 1);
    i_des_data = 8'h99;
    i_des_ready = 1'b1;
    exp_enq.push_back(8'h99);
    held = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (o_q_enqueue || o_des_ack) held++;
    end
    check_eq("fill_held", held, 0);
    i_deq_req = 1'b1;
    exp_deq.push_back(1);
    step(1);
    i_deq_req = 1'b0;
    check_eq("fill_deq", {31'd0, o_q_dequeue}, 1);
    step(1);
    check_eq("fill_blackout", {31'd0, o_q_enqueue}, 0);
    check_eq("fill_len7", {28'd0, q_len}, 7);
    step(1);
    check_eq("fill_enq9", {31'd0, o_q_enqueue}, 1);
    step(1);
    check_eq("fill_ack9", {31'd0, o_des_ack}, 1);
    i_des_ready = 1'b0;
    step(2);
    check_eq("fill_full_again", {31'd0, o_full}, 1);

    // Dequeue request against an empty queue.
    do_reset(4'd0);
    i_deq_req = 1'b1;
    exp_deq.push_back(2);
    step(1);
    i_deq_req = 1'b0;
    check_eq("empty_err", {31'd0, o_deq_err}, 1);
    check_eq("empty_no_deq", {31'd0, o_q_dequeue}, 0);
    step(1);
    check_eq("empty_err_once", {31'd0, o_deq_err}, 0);
    step(2);
    check_eq("empty_pending_clr", {30'd0, o_deq_err, o_q_dequeue}, 0);

    // Contention: enqueue wins the first tie, then order flips once enqueue went last.
    do_reset(4'd4);
    tie_round(8'h3C, 1'b1);
    send_word(8'h5A);
    tie_round(8'hC3, 1'b0);

    // Asynchronous reset while a word sits in HOLD being granted.
    do_reset(4'd0);
    i_des_data = 8'h77;
    i_des_ready = 1'b1;
    exp_enq.push_back(8'h77);
    step(1);
    check_eq("arst_pre_enq", {31'd0, o_q_enqueue}, 1);
    #2;
    rst_n = 1'b0;
    i_des_ready = 1'b0;
    #1;
    check_eq("arst_enq", {31'd0, o_q_enqueue}, 0);
    check_eq("arst_data", {24'd0, o_q_data}, 0);
    check_eq("arst_ack", {31'd0, o_des_ack}, 0);
    step(1);
    rst_n = 1'b1;
    base_ack = ack_count;
    step(5);
    check_eq("arst_no_ack", ack_count - base_ack, 0);
    send_word(8'h42);

    // Ready stuck high for 20 cycles gives one capture only.
    do_reset(4'd0);
    i_des_data = 8'hE1;
    i_des_ready = 1'b1;
    exp_enq.push_back(8'hE1);
    base_enq = enq_count;
    base_ack = ack_count;
    step(20);
    check_eq("stuck_enq", enq_count - base_enq, 1);
    check_eq("stuck_ack", ack_count - base_ack, 1);
    i_des_ready = 1'b0;
    step(2);
    i_des_data = 8'h1E;
    i_des_ready = 1'b1;
    exp_enq.push_back(8'h1E);
    step(1);
    check_eq("stuck_idle_enq", {31'd0, o_q_enqueue}, 1);
    step(1);
    check_eq("stuck_idle_ack", {31'd0, o_des_ack}, 1);
    i_des_ready = 1'b0;
    step(3);

    check_eq("sb_enq_drained", exp_enq.size(), 0);
    check_eq("sb_deq_drained", exp_deq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
